// File: rtl/detector_pkg.sv
// detector_pkg
//   Shared definitions for the run-detector arbiter.
//   state_t          : arbiter FSM state encoding
//   DET_CLEAR_CYCLES : cycles the detector reset is held before a burst
package detector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  localparam int DET_CLEAR_CYCLES = 1;

endpackage

// File: rtl/detector_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker: selects the first set request at or
//   after rr_ptr, scanning upward with wrap-around.
//   req        : request vector
//   rr_ptr     : index with the highest priority this round
//   winner     : one-hot winning request (0 when no request)
//   winner_idx : binary index of the winner
//   any        : at least one request is set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < N; k++) begin
      // rr_ptr + k stays below 2*N, so one conditional subtract is the modulo.
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      idx = sum[IW-1:0];
      if (!any && req[idx]) begin
        any         = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/detector_arbiter.sv
// detector_arbiter
//   Shares one run detector among N_REQ serial requesters. Each granted
//   burst is preceded by a detector clear; z is counted while the burst
//   streams and the result is reported with a one-cycle done pulse.
//   clk, rst    : clock, asynchronous active-high reset
//   req         : per-channel request level (sampled only in IDLE)
//   burst_len   : per-channel burst length, slice i = [i*LEN_W +: LEN_W]
//   bit_in      : per-channel serial data
//   bit_rd      : one-hot, channel advances to its next bit next cycle
//   grant       : one-hot owner of the detector, 0 when idle
//   done        : one-cycle completion pulse per channel
//   hit         : z was seen high during the burst (valid with done)
//   hit_cycles  : saturating count of sampled z-high cycles (valid with done)
//   det_rst     : detector reset
//   det_w       : detector serial input
//   det_z       : detector output
module detector_arbiter
  import detector_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] burst_len,
  input  logic [N_REQ-1:0]       bit_in,
  output logic [N_REQ-1:0]       bit_rd,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   hit,
  output logic [LEN_W-1:0]       hit_cycles,
  output logic                   det_rst,
  output logic                   det_w,
  input  logic                   det_z
);

  localparam int IW    = $clog2(N_REQ);
  localparam int CLR_W = (DET_CLEAR_CYCLES > 1) ? $clog2(DET_CLEAR_CYCLES) : 1;

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [IW-1:0]      gidx_reg, gidx_next;
  logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;
  logic [CLR_W-1:0]   clr_cnt_reg, clr_cnt_next;
  logic               samp_reg, samp_next;
  logic               hit_reg, hit_next;
  logic [LEN_W-1:0]   hit_cycles_reg, hit_cycles_next;
  logic               det_rst_reg, det_rst_next;
  logic [N_REQ-1:0]   bit_rd_reg, bit_rd_next;
  logic [N_REQ-1:0]   done_reg, done_next;

  logic [LEN_W-1:0]   len_arr [N_REQ];
  logic [N_REQ-1:0]   pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               sample_now;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len
    assign len_arr[gi] = burst_len[gi*LEN_W +: LEN_W];
  end

  rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_reg),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  // z reflects the previous bit, so the first STREAM cycle has nothing to
  // sample yet and DRAIN picks up the result of the final bit.
  assign sample_now = ((state_reg == ST_STREAM) && samp_reg) || (state_reg == ST_DRAIN);

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    gidx_next       = gidx_reg;
    rr_ptr_next     = rr_ptr_reg;
    cnt_next        = cnt_reg;
    clr_cnt_next    = clr_cnt_reg;
    samp_next       = samp_reg;
    hit_next        = hit_reg;
    hit_cycles_next = hit_cycles_reg;
    det_rst_next    = 1'b0;
    bit_rd_next     = '0;
    done_next       = '0;

    if (sample_now && det_z) begin
      hit_next = 1'b1;
      if (hit_cycles_reg != '1) begin
        hit_cycles_next = hit_cycles_reg + LEN_W'(1);
      end
    end

    case (state_reg)
      ST_IDLE: begin
        if (pick_any) begin
          state_next      = ST_CLEAR;
          grant_next      = pick_onehot;
          gidx_next       = pick_idx;
          cnt_next        = len_arr[pick_idx];
          clr_cnt_next    = '0;
          samp_next       = 1'b0;
          hit_next        = 1'b0;
          hit_cycles_next = '0;
          // A zero-length burst leaves the detector untouched.
          det_rst_next    = (len_arr[pick_idx] != '0);
        end
      end
      ST_CLEAR: begin
        if (cnt_reg == '0) begin
          state_next = ST_REPORT;
          done_next  = grant_reg;
        end else if (clr_cnt_reg == CLR_W'(DET_CLEAR_CYCLES - 1)) begin
          state_next  = ST_STREAM;
          bit_rd_next = grant_reg;
        end else begin
          clr_cnt_next = clr_cnt_reg + CLR_W'(1);
          det_rst_next = 1'b1;
        end
      end
      ST_STREAM: begin
        samp_next = 1'b1;
        cnt_next  = cnt_reg - LEN_W'(1);
        if (cnt_reg == LEN_W'(1)) begin
          state_next = ST_DRAIN;
        end else begin
          bit_rd_next = grant_reg;
        end
      end
      ST_DRAIN: begin
        state_next = ST_REPORT;
        done_next  = grant_reg;
      end
      ST_REPORT: begin
        state_next  = ST_IDLE;
        grant_next  = '0;
        rr_ptr_next = (gidx_reg == IW'(N_REQ - 1)) ? '0 : gidx_reg + IW'(1);
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      gidx_reg       <= '0;
      rr_ptr_reg     <= '0;
      cnt_reg        <= '0;
      clr_cnt_reg    <= '0;
      samp_reg       <= 1'b0;
      hit_reg        <= 1'b0;
      hit_cycles_reg <= '0;
      det_rst_reg    <= 1'b1;
      bit_rd_reg     <= '0;
      done_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      gidx_reg       <= gidx_next;
      rr_ptr_reg     <= rr_ptr_next;
      cnt_reg        <= cnt_next;
      clr_cnt_reg    <= clr_cnt_next;
      samp_reg       <= samp_next;
      hit_reg        <= hit_next;
      hit_cycles_reg <= hit_cycles_next;
      det_rst_reg    <= det_rst_next;
      bit_rd_reg     <= bit_rd_next;
      done_reg       <= done_next;
    end
  end

  assign grant      = grant_reg;
  assign bit_rd     = bit_rd_reg;
  assign done       = done_reg;
  assign hit        = hit_reg;
  assign hit_cycles = hit_cycles_reg;
  assign det_rst    = det_rst_reg;
  // DRAIN keeps the channel's last bit on the detector input.
  assign det_w      = ((state_reg == ST_STREAM) || (state_reg == ST_DRAIN)) ? bit_in[gidx_reg] : 1'b0;

endmodule

// File: tb/tb_detector_arbiter.sv
// tb_detector_arbiter
//   Randomized and directed bench for detector_arbiter with a behavioural
//   run-of-four-ones detector attached to the det_* pins. Expected results
//   are queued per channel at issue time; a monitor checks every grant,
//   bit read and done pulse against an arithmetic reference.
module tb_detector_arbiter;

  localparam int N  = 4;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req, bit_in, bit_rd, grant, done;
  logic [N*LW-1:0]   burst_len;
  logic              hit, det_rst, det_w, det_z;
  logic [LW-1:0]     hit_cycles;

  always #5 clk = ~clk;

  detector_arbiter #(.N_REQ(N), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .burst_len  (burst_len),
    .bit_in     (bit_in),
    .bit_rd     (bit_rd),
    .grant      (grant),
    .done       (done),
    .hit        (hit),
    .hit_cycles (hit_cycles),
    .det_rst    (det_rst),
    .det_w      (det_w),
    .det_z      (det_z)
  );

  // Run detector: z is high while the last four accepted bits were all 1.
  logic [2:0] run_reg;
  always @(posedge clk) begin
    if (det_rst)      run_reg <= 3'd0;
    else if (!det_w)  run_reg <= 3'd0;
    else if (run_reg != 3'd4) run_reg <= run_reg + 3'd1;
  end
  assign det_z = (run_reg == 3'd4);

  typedef struct { int len; logic [255:0] bits; } txn_t;
  typedef struct { int len; logic hit; int cyc; } exp_t;

  txn_t ch_q  [N][$];
  exp_t exp_q [N][$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ptr_m    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Each bit j (1-based) leaves z high in the sample that follows it when
  // bits j-3..j are all ones; the count saturates at 2^LW-1.
  function automatic void ref_result(input int len, input logic [255:0] bits,
                                     output logic h, output int c);
    c = 0;
    for (int j = 4; j <= len; j++) begin
      if (bits[j-1] && bits[j-2] && bits[j-3] && bits[j-4]) c++;
    end
    if (c > (1 << LW) - 1) c = (1 << LW) - 1;
    h = (c > 0);
  endfunction

  function automatic int rr_first(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic issue(input int ch, input int len, input logic [255:0] bits);
    txn_t t;
    exp_t e;
    logic h;
    int   c;
    t.len  = len;
    t.bits = bits;
    ch_q[ch].push_back(t);
    ref_result(len, bits, h, c);
    e.len = len;
    e.hit = h;
    e.cyc = c;
    exp_q[ch].push_back(e);
  endtask

  function automatic logic [255:0] rand_bits();
    logic [255:0] a, b;
    a = {8{$urandom()}};
    b = {8{$urandom()}};
    return a | b;
  endfunction

  // Channel models: present the head transaction, advance on bit_rd,
  // retire on done, restart from bit 0 after a reset.
  initial begin : channels
    logic [N-1:0] rd_seen, done_seen;
    int pos [N];
    req = '0; bit_in = '0; burst_len = '0;
    for (int i = 0; i < N; i++) pos[i] = 0;
    forever begin
      @(negedge clk);
      rd_seen   = bit_rd;
      done_seen = done;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          pos[i] = 0;
        end else if (done_seen[i]) begin
          if (ch_q[i].size() > 0) void'(ch_q[i].pop_front());
          pos[i] = 0;
        end else if (rd_seen[i] && ch_q[i].size() > 0 && pos[i] < ch_q[i][0].len - 1) begin
          pos[i]++;
        end
        if (ch_q[i].size() > 0) begin
          req[i] = 1'b1;
          burst_len[i*LW +: LW] = LW'(ch_q[i][0].len);
          bit_in[i] = ch_q[i][0].bits[pos[i]];
        end else begin
          req[i] = 1'b0;
          bit_in[i] = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin : monitor
    logic [N-1:0] req_prev;
    logic idle_prev, idle_now, busy, rd_any, have_exp;
    int g_ch, g_start, rst_pulses, rd_cnt, w;
    exp_t e;
    req_prev = '0; idle_prev = 1'b0; busy = 1'b0; rd_any = 1'b0;
    g_ch = 0; g_start = 0; rst_pulses = 0; rd_cnt = 0;
    forever begin
      @(negedge clk);
      idle_now = 1'b0;
      if (rst) begin
        busy  = 1'b0;
        ptr_m = 0;
      end else if (!busy) begin
        if (idle_prev && req_prev != '0) begin
          w = rr_first(req_prev, ptr_m);
          check("grant", grant, onehot(w));
          busy       = 1'b1;
          g_ch       = w;
          g_start    = cyc;
          rst_pulses = det_rst ? 1 : 0;
          rd_cnt     = 0;
          rd_any     = 1'b0;
        end else begin
          check("grant_idle", grant, '0);
          check("done_idle", done, '0);
          idle_now = 1'b1;
        end
      end else begin
        check("grant_hold", grant, onehot(g_ch));
        if (det_rst) rst_pulses++;
        if (bit_rd != '0) begin
          check("bit_rd_ch", bit_rd, onehot(g_ch));
          if (!rd_any) check("clear_before_bit", rst_pulses, 1);
          rd_any = 1'b1;
          rd_cnt++;
        end
        if (done != '0) begin
          have_exp = (exp_q[g_ch].size() > 0);
          check("exp_present", have_exp, 1);
          if (have_exp) e = exp_q[g_ch].pop_front();
          else e = '{len: -1, hit: 1'b0, cyc: 0};
          check("done_ch", done, onehot(g_ch));
          check("hit", hit, e.hit);
          check("hit_cycles", hit_cycles, e.cyc);
          check("latency", cyc - g_start, (e.len == 0) ? 1 : e.len + 2);
          check("clear_pulses", rst_pulses, (e.len == 0) ? 0 : 1);
          check("bits_read", rd_cnt, e.len);
          $display("txn ch=%0d len=%0d hit=%0b hit_cycles=%0d latency=%0d",
                   g_ch, e.len, hit, hit_cycles, cyc - g_start);
          ptr_m = (g_ch + 1) % N;
          busy  = 1'b0;
        end else if (cyc - g_start > 400) begin
          check("done_timeout", cyc - g_start, 0);
          busy = 1'b0;
        end
      end
      idle_prev = idle_now;
      req_prev  = req;
    end
  end

  task automatic wait_all(input int budget);
    int k = 0;
    while (pending() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("queue_drain", pending(), 0);
    for (int i = 0; i < N; i++) begin
      ch_q[i].delete();
      exp_q[i].delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cnt;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, '0);
    check("rst_bit_rd", bit_rd, '0);
    check("rst_done", done, '0);
    check("rst_hit", hit, 1'b0);
    check("rst_hit_cycles", hit_cycles, '0);
    check("rst_det_rst", det_rst, 1'b1);
    check("rst_det_w", det_w, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("det_rst_after_release", det_rst, 1'b1);
    @(negedge clk);
    check("det_rst_idle", det_rst, 1'b0);

    // Single channel, bits 1,1,1,1,1,0,0,1.
    issue(0, 8, 256'b10011111);
    wait_all(100);
    // Short burst of three ones: never reaches a run of four.
    issue(1, 3, 256'b111);
    wait_all(100);
    // Zero-length burst.
    issue(2, 0, '0);
    wait_all(100);
    // rr_ptr is now 3: channel 3 must win before channel 0.
    issue(0, 4, 256'b1111);
    issue(3, 5, 256'b11111);
    wait_all(100);
    // Bring rr_ptr to 0, then all four request with length 2.
    issue(3, 1, 256'b1);
    wait_all(100);
    for (int i = 0; i < N; i++) issue(i, 2, rand_bits());
    issue(0, 2, rand_bits());
    wait_all(200);

    // Reset in the middle of channel 3's burst; rr_ptr is 3 beforehand.
    issue(2, 1, 256'b0);
    wait_all(100);
    issue(3, 6, 256'b111111);
    cnt = 0;
    while (!grant[3] && cnt < 50) begin @(negedge clk); cnt++; end
    check("rst_test_grant3", grant[3], 1'b1);
    issue(1, 5, 256'b11110);
    cnt = 0;
    for (int k = 0; k < 50 && cnt < 3; k++) begin
      @(negedge clk);
      if (bit_rd[3]) cnt++;
    end
    check("stream_reached", cnt, 3);
    #1 rst = 1'b1;
    #1;
    check("midrst_grant", grant, '0);
    check("midrst_det_rst", det_rst, 1'b1);
    check("midrst_done", done, '0);
    check("midrst_bit_rd", bit_rd, '0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_det_rst_release", det_rst, 1'b1);
    wait_all(200);

    // Randomized traffic.
    for (int k = 0; k < 30; k++) begin
      issue($urandom_range(0, N - 1), $urandom_range(0, 12), rand_bits());
      repeat ($urandom_range(0, 8)) @(posedge clk);
    end
    wait_all(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
